// File: rtl/icache_req_arb_pipe_if.sv
// Request/response bundle between icache fetch sources and the tag-pipeline arbiter.
// master = requesters and downstream ready providers, slave = the arbiter.
interface icache_req_arb_pipe_if #(
  parameter int NUM_CH = 3,
  parameter int PLD_W  = 42,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]       req_vld;
  logic [NUM_CH-1:0]       req_rdy;
  logic [NUM_CH*PLD_W-1:0] req_pld;
  logic                    tagram_req_rdy;
  logic                    mshr_tag_req_rdy;
  logic                    tag_req_vld;
  logic [PLD_W-1:0]        tag_req_pld;
  logic [CH_W-1:0]         tag_req_src;

  modport master (
    output req_vld, req_pld, tagram_req_rdy, mshr_tag_req_rdy,
    input  req_rdy, tag_req_vld, tag_req_pld, tag_req_src
  );

  modport slave (
    input  req_vld, req_pld, tagram_req_rdy, mshr_tag_req_rdy,
    output req_rdy, tag_req_vld, tag_req_pld, tag_req_src
  );
endinterface

// File: rtl/icache_req_arb_pipe.sv
// N-channel icache request arbiter with a registered one-entry output slot.
// Default: fixed priority with anti-starvation aging; ICACHE_ARB_RR_EN selects round-robin.
module icache_req_arb_pipe #(
  parameter int NUM_CH    = 3,
  parameter int PLD_W     = 42,
  parameter int STARVE_TH = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic                  clk,
  input logic                  rst,
  icache_req_arb_pipe_if.slave bus
);

  logic              w_dn_rdy;
  logic              w_load_en;
  logic              w_any_vld;
  logic [CH_W-1:0]   w_grant_idx;
  logic [NUM_CH-1:0] w_grant;
  logic [PLD_W-1:0]  w_pld;

  logic              r_vld;
  logic [PLD_W-1:0]  r_pld;
  logic [CH_W-1:0]   r_src;

  assign w_dn_rdy  = bus.tagram_req_rdy & bus.mshr_tag_req_rdy;
  assign w_load_en = !r_vld | w_dn_rdy;
  assign w_any_vld = |bus.req_vld;

`ifdef ICACHE_ARB_RR_EN
  logic [CH_W-1:0] r_ptr;
  logic            w_found;
  int              w_cand;

  // First valid channel at or after the pointer, wrapping modulo NUM_CH.
  always_comb begin
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= NUM_CH) w_cand = w_cand - NUM_CH;
      if (!w_found && bus.req_vld[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = CH_W'(w_cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load_en && w_any_vld) begin
      r_ptr <= (int'(w_grant_idx) == NUM_CH - 1) ? '0 : w_grant_idx + 1'b1;
    end
  end
`else
  logic [3:0]        r_age [NUM_CH];
  logic [NUM_CH-1:0] w_starved;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_starved
    assign w_starved[gi] = (r_age[gi] == 4'(STARVE_TH)) & bus.req_vld[gi];
  end

  // Starved channels pre-empt fixed priority; descending scan leaves the lowest index.
  always_comb begin
    w_grant_idx = '0;
    if (|w_starved) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (w_starved[i]) w_grant_idx = CH_W'(i);
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (bus.req_vld[i]) w_grant_idx = CH_W'(i);
    end
  end

  // Only load cycles count as a lost arbitration; stalls leave the age untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || !bus.req_vld[i] || bus.req_rdy[i]) begin
        r_age[i] <= 4'd0;
      end else if (w_load_en) begin
        r_age[i] <= (r_age[i] >= 4'(STARVE_TH)) ? 4'(STARVE_TH) : r_age[i] + 4'd1;
      end
    end
  end
`endif

  always_comb begin
    w_grant = '0;
    if (w_any_vld) w_grant[w_grant_idx] = 1'b1;
  end

  always_comb begin
    w_pld = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_grant[i]) w_pld = bus.req_pld[i*PLD_W +: PLD_W];
  end

  assign bus.req_rdy = (rst || !w_load_en) ? '0 : w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_pld <= '0;
      r_src <= '0;
    end else if (w_load_en) begin
      r_vld <= w_any_vld;
      if (w_any_vld) begin
        r_pld <= w_pld;
        r_src <= w_grant_idx;
      end
    end
  end

  assign bus.tag_req_vld = r_vld;
  assign bus.tag_req_pld = r_pld;
  assign bus.tag_req_src = r_src;

endmodule

// File: tb/tb_icache_req_arb_pipe.sv
// Directed bench for icache_req_arb_pipe (3 channels, STARVE_TH=8).
// Fixed-priority build checks aging; with ICACHE_ARB_RR_EN it checks round-robin order.
module tb_icache_req_arb_pipe;
  localparam int NUM_CH = 3;
  localparam int PLD_W  = 42;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  icache_req_arb_pipe_if #(.NUM_CH(NUM_CH), .PLD_W(PLD_W), .CH_W(CH_W)) bus ();

  icache_req_arb_pipe #(.NUM_CH(NUM_CH), .PLD_W(PLD_W), .STARVE_TH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pld(input int ch, input logic [PLD_W-1:0] v);
    bus.req_pld[ch*PLD_W +: PLD_W] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_vld = 3'b111;
    bus.tagram_req_rdy = 1'b1;
    bus.mshr_tag_req_rdy = 1'b1;
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_rdy: got %b want 000", bus.req_rdy); end
    step();
    n_tests++;
    if (bus.tag_req_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", bus.tag_req_vld); end
    n_tests++;
    if (bus.tag_req_pld !== '0) begin n_fail++; $display("FAIL reset_pld: got %h want 0", bus.tag_req_pld); end
    n_tests++;
    if (bus.tag_req_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus.tag_req_src); end
`ifndef ICACHE_ARB_RR_EN
    n_tests++;
    if (dut.r_age[0] !== 4'd0 || dut.r_age[1] !== 4'd0 || dut.r_age[2] !== 4'd0) begin
      n_fail++; $display("FAIL reset_age: got %0d/%0d/%0d want 0/0/0", dut.r_age[0], dut.r_age[1], dut.r_age[2]);
    end
`endif
    bus.req_vld = 3'b000;
    rst = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    bus.req_vld = 3'b100;
    set_pld(0, 42'h3AA);
    set_pld(1, 42'h3BB);
    set_pld(2, 42'h155);
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b100) begin n_fail++; $display("FAIL single_rdy: got %b want 100", bus.req_rdy); end
    step();
    $display("[TB] single load vld=%b src=%0d pld=%h", bus.tag_req_vld, bus.tag_req_src, bus.tag_req_pld);
    n_tests++;
    if (bus.tag_req_vld !== 1'b1 || bus.tag_req_pld !== 42'h155 || bus.tag_req_src !== 2'd2) begin
      n_fail++; $display("FAIL single_out: got vld=%b pld=%h src=%0d want 1/155/2", bus.tag_req_vld, bus.tag_req_pld, bus.tag_req_src);
    end
    bus.req_vld = 3'b000;
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b000) begin n_fail++; $display("FAIL single_idle_rdy: got %b want 000", bus.req_rdy); end
    step();
    n_tests++;
    if (bus.tag_req_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", bus.tag_req_vld); end
  endtask

  task automatic test_priority();
    bus.req_vld = 3'b011;
    set_pld(0, 42'h00A);
    set_pld(1, 42'h00B);
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b001) begin n_fail++; $display("FAIL prio_rdy0: got %b want 001", bus.req_rdy); end
    step();
    $display("[TB] prio load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
    n_tests++;
    if (bus.tag_req_src !== 2'd0 || bus.tag_req_pld !== 42'h00A) begin
      n_fail++; $display("FAIL prio_first: got src=%0d pld=%h want 0/00a", bus.tag_req_src, bus.tag_req_pld);
    end
`ifndef ICACHE_ARB_RR_EN
    n_tests++;
    if (dut.r_age[1] !== 4'd1) begin n_fail++; $display("FAIL prio_age1: got %0d want 1", dut.r_age[1]); end
`endif
    bus.req_vld = 3'b010;
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b010) begin n_fail++; $display("FAIL prio_rdy1: got %b want 010", bus.req_rdy); end
    step();
    $display("[TB] prio load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
    n_tests++;
    if (bus.tag_req_src !== 2'd1 || bus.tag_req_pld !== 42'h00B) begin
      n_fail++; $display("FAIL prio_second: got src=%0d pld=%h want 1/00b", bus.tag_req_src, bus.tag_req_pld);
    end
    bus.req_vld = 3'b000;
    step();
  endtask

  task automatic test_back_to_back();
    bus.req_vld = 3'b010;
    for (int k = 0; k < 4; k++) begin
      set_pld(1, 42'h100 + 42'(k));
      #1;
      n_tests++;
      if (bus.req_rdy !== 3'b010) begin n_fail++; $display("FAIL b2b_rdy[%0d]: got %b want 010", k, bus.req_rdy); end
      step();
      $display("[TB] b2b load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
      n_tests++;
      if (bus.tag_req_vld !== 1'b1 || bus.tag_req_pld !== 42'h100 + 42'(k)) begin
        n_fail++; $display("FAIL b2b_pld[%0d]: got vld=%b pld=%h want 1/%h", k, bus.tag_req_vld, bus.tag_req_pld, 42'h100 + 42'(k));
      end
    end
    bus.req_vld = 3'b000;
    step();
    // Downstream ready toggling with an empty slot must not create an entry.
    bus.tagram_req_rdy = 1'b0;
    step();
    n_tests++;
    if (bus.tag_req_vld !== 1'b0) begin n_fail++; $display("FAIL idle_toggle0: got %b want 0", bus.tag_req_vld); end
    bus.tagram_req_rdy = 1'b1;
    step();
    n_tests++;
    if (bus.tag_req_vld !== 1'b0) begin n_fail++; $display("FAIL idle_toggle1: got %b want 0", bus.tag_req_vld); end
  endtask

`ifndef ICACHE_ARB_RR_EN
  task automatic test_starve();
    logic [2:0] exp_rdy;
    logic [1:0] exp_src;
    bus.req_vld = 3'b101;
    set_pld(0, 42'h0AA);
    set_pld(2, 42'h2CC);
    for (int c = 1; c <= 10; c++) begin
      exp_rdy = (c == 9) ? 3'b100 : 3'b001;
      exp_src = (c == 9) ? 2'd2 : 2'd0;
      #1;
      n_tests++;
      if (bus.req_rdy !== exp_rdy) begin n_fail++; $display("FAIL starve_rdy[%0d]: got %b want %b", c, bus.req_rdy, exp_rdy); end
      step();
      $display("[TB] starve cycle %0d src=%0d pld=%h", c, bus.tag_req_src, bus.tag_req_pld);
      n_tests++;
      if (bus.tag_req_src !== exp_src) begin n_fail++; $display("FAIL starve_src[%0d]: got %0d want %0d", c, bus.tag_req_src, exp_src); end
      if (c == 8) begin
        n_tests++;
        if (dut.r_age[2] !== 4'd8) begin n_fail++; $display("FAIL starve_age_sat: got %0d want 8", dut.r_age[2]); end
      end
    end
    bus.req_vld = 3'b000;
    step();
  endtask

  task automatic test_backpressure();
    bus.req_vld = 3'b011;
    set_pld(0, 42'h033);
    set_pld(1, 42'h044);
    set_pld(2, 42'h055);
    step();
    $display("[TB] bp load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
    bus.mshr_tag_req_rdy = 1'b0;
    bus.req_vld = 3'b110;
    for (int s = 0; s < 5; s++) begin
      #1;
      n_tests++;
      if (bus.req_rdy !== 3'b000) begin n_fail++; $display("FAIL bp_rdy[%0d]: got %b want 000", s, bus.req_rdy); end
      step();
      n_tests++;
      if (bus.tag_req_vld !== 1'b1 || bus.tag_req_pld !== 42'h033 || bus.tag_req_src !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got vld=%b pld=%h src=%0d want 1/033/0", s, bus.tag_req_vld, bus.tag_req_pld, bus.tag_req_src);
      end
      n_tests++;
      if (dut.r_age[1] !== 4'd1 || dut.r_age[2] !== 4'd0) begin
        n_fail++; $display("FAIL bp_age[%0d]: got %0d/%0d want 1/0", s, dut.r_age[1], dut.r_age[2]);
      end
    end
    bus.mshr_tag_req_rdy = 1'b1;
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b010) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 010", bus.req_rdy); end
    step();
    $display("[TB] bp load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
    n_tests++;
    if (bus.tag_req_vld !== 1'b1 || bus.tag_req_src !== 2'd1 || bus.tag_req_pld !== 42'h044) begin
      n_fail++; $display("FAIL bp_reload: got vld=%b src=%0d pld=%h want 1/1/044", bus.tag_req_vld, bus.tag_req_src, bus.tag_req_pld);
    end
    n_tests++;
    if (dut.r_age[2] !== 4'd1) begin n_fail++; $display("FAIL bp_age2_after: got %0d want 1", dut.r_age[2]); end
    bus.req_vld = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_stall();
    bus.req_vld = 3'b110;
    set_pld(1, 42'h066);
    set_pld(2, 42'h077);
    step();
    bus.mshr_tag_req_rdy = 1'b0;
    bus.req_vld = 3'b100;
    step();
    step();
    n_tests++;
    if (bus.tag_req_vld !== 1'b1 || dut.r_age[2] !== 4'd1) begin
      n_fail++; $display("FAIL mrst_pre: got vld=%b age2=%0d want 1/1", bus.tag_req_vld, dut.r_age[2]);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b000) begin n_fail++; $display("FAIL mrst_rdy: got %b want 000", bus.req_rdy); end
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.tag_req_vld !== 1'b0) begin n_fail++; $display("FAIL mrst_vld: got %b want 0", bus.tag_req_vld); end
    n_tests++;
    if (dut.r_age[0] !== 4'd0 || dut.r_age[1] !== 4'd0 || dut.r_age[2] !== 4'd0) begin
      n_fail++; $display("FAIL mrst_age: got %0d/%0d/%0d want 0/0/0", dut.r_age[0], dut.r_age[1], dut.r_age[2]);
    end
    #1;
    n_tests++;
    if (bus.req_rdy !== 3'b100) begin n_fail++; $display("FAIL mrst_after_rdy: got %b want 100", bus.req_rdy); end
    step();
    $display("[TB] mrst load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
    n_tests++;
    if (bus.tag_req_vld !== 1'b1 || bus.tag_req_src !== 2'd2 || bus.tag_req_pld !== 42'h077) begin
      n_fail++; $display("FAIL mrst_after_load: got vld=%b src=%0d pld=%h want 1/2/077", bus.tag_req_vld, bus.tag_req_src, bus.tag_req_pld);
    end
    bus.req_vld = 3'b000;
    bus.mshr_tag_req_rdy = 1'b1;
    step();
    step();
  endtask
`else
  task automatic test_rr();
    logic [1:0] exp_src;
    bus.req_vld = 3'b111;
    set_pld(0, 42'h0A0);
    set_pld(1, 42'h0A1);
    set_pld(2, 42'h0A2);
    for (int c = 0; c < 6; c++) begin
      exp_src = 2'(c % 3);
      step();
      $display("[TB] rr load src=%0d pld=%h", bus.tag_req_src, bus.tag_req_pld);
      n_tests++;
      if (bus.tag_req_src !== exp_src || bus.tag_req_vld !== 1'b1) begin
        n_fail++; $display("FAIL rr_src[%0d]: got src=%0d vld=%b want %0d/1", c, bus.tag_req_src, bus.tag_req_vld, exp_src);
      end
    end
    bus.req_vld = 3'b000;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_vld = '0;
    bus.req_pld = '0;
    bus.tagram_req_rdy = 1'b1;
    bus.mshr_tag_req_rdy = 1'b1;
    test_reset();
    test_single();
`ifndef ICACHE_ARB_RR_EN
    test_priority();
    test_back_to_back();
    test_starve();
    test_backpressure();
    test_reset_mid_stall();
`else
    test_rr();
    test_priority();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
